// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator: pixel request stage, sync/blank alignment and DAC output register.
// Optional colour-bar source enabled by VGA_TEST_PATTERN_EN (adds the test_mode input).
module vga_timing_gen #(
  parameter int unsigned H_VIS     = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SW      = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VIS     = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SW      = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned COLOR_LAT = 1
) (
  input  logic        clk_50,
  input  logic        reset_n,
  input  logic [9:0]  pix_r,
  input  logic [9:0]  pix_g,
  input  logic [9:0]  pix_b,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  output logic [9:0]  req_x,
  output logic [9:0]  req_y,
  output logic        req_valid,
  output logic        frame_start,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank,
  output logic        vga_sync,
  output logic        vga_clk,
  output logic [9:0]  vga_r,
  output logic [9:0]  vga_g,
  output logic [9:0]  vga_b
);

  localparam int unsigned CW     = 10;
  localparam int unsigned H_TOT  = H_VIS + H_FP + H_SW + H_BP;
  localparam int unsigned V_TOT  = V_VIS + V_FP + V_SW + V_BP;
  localparam int unsigned HS_BEG = H_VIS + H_FP;
  localparam int unsigned HS_END = HS_BEG + H_SW;
  localparam int unsigned VS_BEG = V_VIS + V_FP;
  localparam int unsigned VS_END = VS_BEG + V_SW;

  logic               pix_en_q, pix_en_d;
  logic               vga_clk_q, vga_clk_d;
  logic [CW-1:0]      h_q, h_d, v_q, v_d;
  logic [CW-1:0]      req_x_q, req_x_d, req_y_q, req_y_d;
  logic               req_valid_q, req_valid_d;
  logic               hs_raw_q, hs_raw_d, vs_raw_q, vs_raw_d;
  logic [COLOR_LAT:0] de_sr_q, de_sr_d, hs_sr_q, hs_sr_d, vs_sr_q, vs_sr_d;
  logic               frame_start_q, frame_start_d;
  logic [CW-1:0]      r_q, r_d, g_q, g_d, b_q, b_d;
  logic [CW-1:0]      src_r, src_g, src_b;

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BW = 3;

  logic [BW*COLOR_LAT-1:0] bar_sr_q, bar_sr_d;
  logic [BW-1:0]           bar_idx, bar_last;

  // Bar index follows the request through the same latency the renderer has.
  assign bar_idx  = BW'(req_x_q / CW'(H_VIS / 8));
  assign bar_last = bar_sr_q[BW*COLOR_LAT-1 -: BW];

  always_comb begin
    bar_sr_d = bar_sr_q;
    if (pix_en_q) bar_sr_d = (BW*COLOR_LAT)'({bar_sr_q, bar_idx});
  end

  // Bar order white, yellow, cyan, green, magenta, red, blue, black maps to inverted index bits.
  always_comb begin
    src_r = pix_r;
    src_g = pix_g;
    src_b = pix_b;
    if (test_mode) begin
      src_r = {CW{~bar_last[1]}};
      src_g = {CW{~bar_last[2]}};
      src_b = {CW{~bar_last[0]}};
    end
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) bar_sr_q <= '0;
    else          bar_sr_q <= bar_sr_d;
  end
`else
  assign src_r = pix_r;
  assign src_g = pix_g;
  assign src_b = pix_b;
`endif

  // Counters, raw timing and the sync/blank/colour alignment pipeline.
  always_comb begin
    pix_en_d      = ~pix_en_q;
    vga_clk_d     = pix_en_d;
    h_d           = h_q;
    v_d           = v_q;
    frame_start_d = 1'b0;
    de_sr_d       = de_sr_q;
    hs_sr_d       = hs_sr_q;
    vs_sr_d       = vs_sr_q;
    r_d           = r_q;
    g_d           = g_q;
    b_d           = b_q;
    if (pix_en_q) begin
      if (h_q == CW'(H_TOT - 1)) begin
        h_d = '0;
        if (v_q == CW'(V_TOT - 1)) begin
          v_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          v_d = v_q + CW'(1);
        end
      end else begin
        h_d = h_q + CW'(1);
      end
      de_sr_d = {de_sr_q[COLOR_LAT-1:0], req_valid_q};
      hs_sr_d = {hs_sr_q[COLOR_LAT-1:0], hs_raw_q};
      vs_sr_d = {vs_sr_q[COLOR_LAT-1:0], vs_raw_q};
      r_d     = de_sr_q[COLOR_LAT-1] ? src_r : '0;
      g_d     = de_sr_q[COLOR_LAT-1] ? src_g : '0;
      b_d     = de_sr_q[COLOR_LAT-1] ? src_b : '0;
    end
    // Request/raw timing registers track the next counter value so they mirror the counters.
    req_valid_d = (h_d < CW'(H_VIS)) && (v_d < CW'(V_VIS));
    req_x_d     = req_valid_d ? h_d : '0;
    req_y_d     = req_valid_d ? v_d : '0;
    hs_raw_d    = !((h_d >= CW'(HS_BEG)) && (h_d < CW'(HS_END)));
    vs_raw_d    = !((v_d >= CW'(VS_BEG)) && (v_d < CW'(VS_END)));
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      pix_en_q      <= 1'b0;
      vga_clk_q     <= 1'b0;
      h_q           <= '0;
      v_q           <= '0;
      req_x_q       <= '0;
      req_y_q       <= '0;
      req_valid_q   <= 1'b0;
      hs_raw_q      <= 1'b1;
      vs_raw_q      <= 1'b1;
      de_sr_q       <= '0;
      hs_sr_q       <= '1;
      vs_sr_q       <= '1;
      frame_start_q <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
    end else begin
      pix_en_q      <= pix_en_d;
      vga_clk_q     <= vga_clk_d;
      h_q           <= h_d;
      v_q           <= v_d;
      req_x_q       <= req_x_d;
      req_y_q       <= req_y_d;
      req_valid_q   <= req_valid_d;
      hs_raw_q      <= hs_raw_d;
      vs_raw_q      <= vs_raw_d;
      de_sr_q       <= de_sr_d;
      hs_sr_q       <= hs_sr_d;
      vs_sr_q       <= vs_sr_d;
      frame_start_q <= frame_start_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
    end
  end

  assign req_x       = req_x_q;
  assign req_y       = req_y_q;
  assign req_valid   = req_valid_q;
  assign frame_start = frame_start_q;
  assign vga_hsync   = hs_sr_q[COLOR_LAT];
  assign vga_vsync   = vs_sr_q[COLOR_LAT];
  assign vga_blank   = de_sr_q[COLOR_LAT];
  assign vga_sync    = 1'b0;
  assign vga_clk     = vga_clk_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;

endmodule
